// File: rtl/hpdmc_dqoe_seq.sv
// HPDMC data-path bus-direction sequencer: drives per-lane OBUFT tristate and DQM
// controls from read/write strobes, enforcing burst windows and read-to-write turnaround.
module hpdmc_dqoe_seq #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CL        = 2
) (
   input  logic                         sys_clk,
   input  logic                         sdram_rst,
   input  logic                         write,
   input  logic                         read,
   input  logic [LANES*BURST_LEN-1:0]   wr_mask,
   output logic [LANES-1:0]             dq_t,
   output logic [LANES-1:0]             dqm_o,
   output logic                         write_ready,
   output logic                         read_ready,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned MASK_W = LANES * BURST_LEN;
   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned CNT_W  = $clog2(CL + BURST_LEN);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CL + BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_TURN  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MASK_W-1:0]   mask_q, mask_d;
   logic [LANES-1:0]    dq_t_q, dq_t_d;
   logic [LANES-1:0]    dqm_q, dqm_d;
   logic                err_q, err_d;
   logic                wr_acc, rd_acc;

   // Readiness decoded from state registers only
   assign write_ready = (state_q == S_IDLE)
                      || ((state_q == S_TURN)  && (cnt_q == '0))
                      || ((state_q == S_WRITE) && (beat_q == BEAT_LAST));
   assign read_ready  = (state_q == S_IDLE) || (state_q == S_TURN);
   assign busy        = (state_q != S_IDLE);

   // A simultaneous read is dropped; write is judged on its own
   assign wr_acc = write && write_ready;
   assign rd_acc = read && !write && read_ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      dq_t_d  = dq_t_q;
      dqm_d   = dqm_q;
      err_d   = (write && !write_ready) || (read && !read_ready) || (read && write);

      case (state_q)
         S_IDLE: begin
            dq_t_d = '1;
            dqm_d  = '1;
         end
         S_WRITE: begin
            if (beat_q == BEAT_LAST) begin
               state_d = S_IDLE;
               dq_t_d  = '1;
               dqm_d   = '1;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
               dq_t_d = '0;
               dqm_d  = mask_q[LANES-1:0];
               mask_d = mask_q >> LANES;
            end
         end
         S_TURN: begin
            dq_t_d = '1;
            dqm_d  = '0;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               dqm_d   = '1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            dq_t_d  = '1;
            dqm_d   = '1;
         end
      endcase

      // Outputs register the next state's beat, so drive starts one cycle after accept
      if (wr_acc) begin
         state_d = S_WRITE;
         beat_d  = '0;
         dq_t_d  = '0;
         dqm_d   = wr_mask[LANES-1:0];
         mask_d  = wr_mask >> LANES;
      end else if (rd_acc) begin
         state_d = S_TURN;
         cnt_d   = CNT_LOAD;
         dq_t_d  = '1;
         dqm_d   = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         dq_t_q  <= '1;
         dqm_q   <= '1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dq_t_q  <= dq_t_d;
         dqm_q   <= dqm_d;
         err_q   <= err_d;
      end
   end

   assign dq_t  = dq_t_q;
   assign dqm_o = dqm_q;
   assign err   = err_q;

endmodule

// File: tb/tb_hpdmc_dqoe_seq.sv
// Directed bench for hpdmc_dqoe_seq (LANES=4, BURST_LEN=4, CL=2) with hand-computed expectations.
module tb_hpdmc_dqoe_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        write, read;
   logic [15:0] wr_mask;
   logic [3:0]  dq_t, dqm_o;
   logic        write_ready, read_ready, busy, err;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   hpdmc_dqoe_seq #(.LANES(4), .BURST_LEN(4), .CL(2)) dut (
      .sys_clk     (clk),
      .sdram_rst   (rst),
      .write       (write),
      .read        (read),
      .wr_mask     (wr_mask),
      .dq_t        (dq_t),
      .dqm_o       (dqm_o),
      .write_ready (write_ready),
      .read_ready  (read_ready),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Advance one cycle; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".dq_t"}, 16'(dq_t), 16'hF);
      chk({tag, ".dqm"},  16'(dqm_o), 16'hF);
      chk({tag, ".wrdy"}, 16'(write_ready), 16'h1);
      chk({tag, ".rrdy"}, 16'(read_ready), 16'h1);
      chk({tag, ".busy"}, 16'(busy), 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] exp_a [4];
      logic [3:0] exp_b [4];
      rst = 1'b1; write = 1'b0; read = 1'b0; wr_mask = '0;
      tick(); tick();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_idle("idle");
         chk("idle.err", 16'(err), 16'h0);
      end

      // Single write, mask 8421 -> beats 1,2,4,8
      exp_a = '{4'h1, 4'h2, 4'h4, 4'h8};
      wr_mask = 16'h8421; write = 1'b1;
      tick(); write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wr1.dq_t", 16'(dq_t), 16'h0);
         chk("wr1.dqm", 16'(dqm_o), 16'(exp_a[i]));
         chk("wr1.rrdy", 16'(read_ready), 16'h0);
         chk("wr1.wrdy", 16'(write_ready), (i == 3) ? 16'h1 : 16'h0);
         if (i < 3) tick();
      end
      tick();
      chk_idle("wr1.end");

      // Back-to-back writes: 1234 then ABCD
      exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
      exp_b = '{4'hD, 4'hC, 4'hB, 4'hA};
      wr_mask = 16'h1234; write = 1'b1;
      tick(); write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b2b.a.dq_t", 16'(dq_t), 16'h0);
         chk("b2b.a.dqm", 16'(dqm_o), 16'(exp_a[i]));
         if (i == 3) begin wr_mask = 16'hABCD; write = 1'b1; end
         tick();
         write = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         chk("b2b.b.dq_t", 16'(dq_t), 16'h0);
         chk("b2b.b.dqm", 16'(dqm_o), 16'(exp_b[i]));
         chk("b2b.b.err", 16'(err), 16'h0);
         tick();
      end
      chk_idle("b2b.end");

      // Read at N, write tried at N+3 (rejected) and N+6 (accepted)
      read = 1'b1;
      tick(); read = 1'b0;                       // N+1
      chk("rd.n1.dq_t", 16'(dq_t), 16'hF);
      chk("rd.n1.dqm", 16'(dqm_o), 16'h0);
      chk("rd.n1.wrdy", 16'(write_ready), 16'h0);
      chk("rd.n1.busy", 16'(busy), 16'h1);
      tick();                                    // N+2
      chk("rd.n2.dqm", 16'(dqm_o), 16'h0);
      tick();                                    // N+3
      chk("rd.n3.wrdy", 16'(write_ready), 16'h0);
      chk("rd.n3.rrdy", 16'(read_ready), 16'h1);
      wr_mask = 16'hF0F0; write = 1'b1;
      tick(); write = 1'b0;                      // N+4
      chk("rd.n4.err", 16'(err), 16'h1);
      chk("rd.n4.dq_t", 16'(dq_t), 16'hF);
      chk("rd.n4.dqm", 16'(dqm_o), 16'h0);
      tick();                                    // N+5
      chk("rd.n5.err", 16'(err), 16'h0);
      chk("rd.n5.dqm", 16'(dqm_o), 16'h0);
      chk("rd.n5.wrdy", 16'(write_ready), 16'h0);
      tick();                                    // N+6
      chk("rd.n6.wrdy", 16'(write_ready), 16'h1);
      chk("rd.n6.dq_t", 16'(dq_t), 16'hF);
      wr_mask = 16'hF0F0; write = 1'b1;
      tick(); write = 1'b0;                      // N+7
      exp_a = '{4'h0, 4'hF, 4'h0, 4'hF};
      for (int i = 0; i < 4; i++) begin
         chk("rdwr.dq_t", 16'(dq_t), 16'h0);
         chk("rdwr.dqm", 16'(dqm_o), 16'(exp_a[i]));
         tick();
      end
      chk_idle("rdwr.end");

      // Read during last write beat is rejected; next-cycle read is accepted
      wr_mask = 16'h0000; write = 1'b1;
      tick(); write = 1'b0;                      // M+1
      tick(); tick(); tick();                    // M+4
      chk("wrd.m4.rrdy", 16'(read_ready), 16'h0);
      read = 1'b1;
      tick();                                    // M+5
      chk("wrd.m5.err", 16'(err), 16'h1);
      chk("wrd.m5.dq_t", 16'(dq_t), 16'hF);
      chk("wrd.m5.rrdy", 16'(read_ready), 16'h1);
      tick(); read = 1'b0;                       // M+6
      chk("wrd.m6.busy", 16'(busy), 16'h1);
      chk("wrd.m6.dqm", 16'(dqm_o), 16'h0);
      chk("wrd.m6.err", 16'(err), 16'h0);
      repeat (6) tick();                         // TURN counter 5..0 then IDLE
      chk_idle("wrd.end");

      // Read and write together in IDLE: write wins, err pulses
      wr_mask = 16'h4321; write = 1'b1; read = 1'b1;
      tick(); write = 1'b0; read = 1'b0;
      chk("rw.err", 16'(err), 16'h1);
      chk("rw.dq_t", 16'(dq_t), 16'h0);
      chk("rw.dqm0", 16'(dqm_o), 16'h1);
      tick();
      chk("rw.err2", 16'(err), 16'h0);
      chk("rw.dqm1", 16'(dqm_o), 16'h2);
      tick(); tick(); tick();
      chk_idle("rw.end");

      // Reset mid-burst
      wr_mask = 16'h0000; write = 1'b1;
      tick(); write = 1'b0;                      // M+1
      tick();                                    // M+2
      rst = 1'b1;
      tick(); rst = 1'b0;                        // M+3
      chk_idle("rst.wr");
      tick();
      chk_idle("rst.wr2");

      // Reset mid-TURN, with an err pulse pending
      read = 1'b1;
      tick(); read = 1'b0;
      chk("rst.turn.busy", 16'(busy), 16'h1);
      write = 1'b1;
      tick(); write = 1'b0;
      chk("rst.turn.err", 16'(err), 16'h1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk_idle("rst.turn");
      chk("rst.turn.err0", 16'(err), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hpdmc_dqoe_seq.md
# hpdmc_dqoe_seq

Write/read bus-direction sequencer for the HPDMC SDRAM data path. It consumes read/write command strobes from the command scheduler and produces the per-lane tristate controls and DQM values that feed the 4-lane `OBUFT` output-buffer stage directly. It enforces burst-length drive windows, seamless back-to-back writes, and read-to-write bus turnaround.

## Interface
- `LANES`, 4: byte lanes; width of the `dq_t` and `dqm_o` buses.
- `BURST_LEN`, 4: beats per burst; valid range 2..8.
- `CL`, 2: CAS latency in cycles; valid range 2..3.

- `sys_clk`  in  1  system/SDRAM clock. One clock domain.
- `sdram_rst`  in  1  reset, synchronous, active-high.
- `write`  in  1  write command issued this cycle. Accepted only when `write_ready`=1.
- `read`  in  1  read command issued this cycle. Accepted only when `read_ready`=1.
- `wr_mask`  in  LANES*BURST_LEN  byte masks for the burst, sampled on write accept. Beat k uses bits [k*LANES +: LANES]; 1 = masked.
- `dq_t`  out  LANES  tristate control to the output buffers; 1 = Hi-Z, 0 = drive.
- `dqm_o`  out  LANES  DQM value to the DQM output buffers.
- `write_ready`  out  1  a write may be accepted this cycle.
- `read_ready`  out  1  a read may be accepted this cycle.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  one-cycle pulse: a strobe arrived while its ready was low, or `read` and `write` arrived together.

## Operation
- States:
  - IDLE: bus released.
  - WRITE: drive window; beat counter 0..BURST_LEN-1.
  - TURN: read window plus turnaround; down-counter.
- Reset, applied on the next edge while `sdram_rst`=1, from any state including mid-burst:
  - state = IDLE
  - `dq_t` = all 1
  - `dqm_o` = all 1
  - `err` = 0
  - mask shift register cleared
  - `write_ready` and `read_ready` read 1 after reset (state IDLE).
- `write_ready` is 1 in IDLE, in TURN when the counter is 0, and in WRITE when the beat counter is BURST_LEN-1. Otherwise 0.
- `read_ready` is 1 in IDLE and in TURN. It is 0 throughout WRITE, including the last beat.
- Write accept, from any state where `write_ready`=1:
  - load `wr_mask` into the shift register
  - go to WRITE with beat = 0
  - next cycle: `dq_t` = 0, `dqm_o` = beat-0 mask.
- WRITE, each cycle:
  - `dq_t` = 0; `dqm_o` = current beat mask; beat increments.
  - After beat BURST_LEN-1: a new write accepted in that same cycle restarts WRITE at beat 0 with no gap. Otherwise go to IDLE.
  - In IDLE: `dq_t` = all 1, `dqm_o` = all 1.
- Read accept:
  - Go to TURN with counter = CL+BURST_LEN-1.
  - In TURN: `dq_t` = all 1, `dqm_o` = 0.
  - The counter decrements each cycle and saturates at 0. In TURN with counter 0 and no new strobe, go to IDLE.
  - A read accepted in TURN reloads the counter, giving back-to-back reads.
- `read` and `write` in the same cycle: write is evaluated alone against `write_ready`, the read is dropped, and `err` pulses.
- Rejected strobe: state unchanged; `err` pulses next cycle.
- `busy` = (state != IDLE).
- `dq_t`, `dqm_o` and `err` are registered. `write_ready`, `read_ready` and `busy` are decoded combinationally from state registers only, with no input-to-output path.
- Counter widths:
  - beat counter: clog2(BURST_LEN)
  - turnaround counter: clog2(CL+BURST_LEN).
  - All arithmetic is unsigned.
  - Counters never wrap: the beat counter leaves WRITE at BURST_LEN-1, and the turnaround counter saturates at 0.

## Timing
- Write accepted at cycle M (BURST_LEN=4): `dq_t` = 0 at M+1..M+4; `dqm_o` = beat masks 0..3 at M+1..M+4; `dq_t` = all 1 at M+5 if there is no follow-on write.
- Latency from command strobe to first registered output change: 1 cycle.
- Back-to-back writes at M and M+4: `dq_t` stays 0 continuously over M+1..M+8.
- Read at N (CL=2, BURST_LEN=4):
  - read data occupies the bus N+2..N+5
  - `write_ready` = 0 at N+1..N+5 and 1 at N+6
  - write at N+6 drives at N+7, leaving a one-cycle Hi-Z gap at N+6.
- Write at M, read requested at M+4: rejected (`read_ready`=0), `err` = 1 at M+5. A read at M+5 is accepted.
- `sdram_rst` at M+2 of a write burst: `dq_t` = all 1 and `dqm_o` = all 1 from M+3.

## Test plan
- Reset, then idle 10 cycles -> `dq_t`=F, `dqm_o`=F, `write_ready`=1, `read_ready`=1, `busy`=0, `err`=0 throughout.
- Single write, `wr_mask`=16'h8421 at M -> `dq_t`=0 at M+1..M+4; `dqm_o`=1,2,4,8 at M+1..M+4; `dq_t`=F at M+5.
- Writes at M and M+4 with different masks -> `dq_t` held at 0 M+1..M+8; `dqm_o` switches to the second mask at M+5.
- Read at N, write attempted at N+3 and again at N+6 -> first attempt gives `err` at N+4 and no drive; second drives at N+7..N+10; `dqm_o`=0 at N+1..N+5.
- `read` and `write` together in IDLE -> write burst runs, read dropped, `err`=1 next cycle.
- `sdram_rst` pulsed mid-burst and mid-TURN -> `dq_t`=F, `dqm_o`=F, IDLE on the next edge; both readies = 1 thereafter.
